// File: rtl/gate_unit_if.sv
// gate_unit_if: request/result handshake bundle for gate_unit.
interface gate_unit_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [2:0]               in_op;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/gate_unit.sv
// gate_unit: bitwise logic unit feeding a first-word-fall-through result FIFO.
module gate_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst_n,
   gate_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] result;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   // Handshake flags come only from the registered count, never from in_*.
   assign bus.in_ready  = count != (AW+1)'(DEPTH);
   assign bus.out_valid = count != '0;
   assign bus.count     = count;
   assign bus.out_data  = mem[rd_ptr];
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   always_comb begin
      result = bus.in_a;
      case (bus.in_op)
         3'b000: result = ~bus.in_a;
         3'b001: result = bus.in_a & bus.in_b;
         3'b010: result = bus.in_a | bus.in_b;
         3'b011: result = bus.in_a ^ bus.in_b;
         3'b100: result = ~(bus.in_a & bus.in_b);
         3'b101: result = ~(bus.in_a | bus.in_b);
         3'b110: result = ~(bus.in_a ^ bus.in_b);
         default: result = bus.in_a;
      endcase
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= result;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
endmodule

// File: doc/gate_unit.md
GATE_UNIT -- requirements
Module: gate_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width (>=1).
REQ-002 Parameter DEPTH, default 4, result buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/op presented this cycle.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_op  input  3  operation select per REQ-012.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B (ignored for NOT/BUF).
REQ-010 out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 out_data  output  WIDTH  result; count  output  $clog2(DEPTH)+1  entries held.

Function
REQ-012 in_op encoding, bitwise across WIDTH: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR, 111 BUF a.
REQ-013 Accept = in_valid & in_ready at a rising edge; result computed from in_op/in_a/in_b sampled at that edge and written to buffer tail.
REQ-014 Pop = out_valid & out_ready at a rising edge; head entry removed.
REQ-015 Buffer is FIFO, first-word-fall-through; out_data = head entry whenever out_valid=1.
REQ-016 Latency: result accepted at edge N is visible on out_data/out_valid after edge N when buffer was empty; no combinational path from in_* to out_*.
REQ-017 in_ready = (count != DEPTH); out_valid = (count != 0); both purely from registered state.
REQ-018 Full (count=DEPTH): in_ready=0, requests not accepted, in_* held by producer; simultaneous pop makes in_ready=1 the following cycle (no same-cycle bypass).
REQ-019 Empty: out_valid=0, out_data value unspecified; a push does not bypass to output in the same cycle.
REQ-020 Simultaneous accept and pop (0<count<DEPTH): count unchanged, ordering preserved.
REQ-021 count increments on accept-only, decrements on pop-only, never exceeds DEPTH nor underflows.
REQ-022 Read/write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 in_valid while in_ready=0 has no effect; out_ready while out_valid=0 has no effect.
REQ-024 out_data shall remain stable while out_valid=1 and out_ready=0.

Reset
REQ-025 rst_n=0 immediately (without clock) forces count=0, pointers=0, out_valid=0, in_ready=1.
REQ-026 Reset mid-operation discards all buffered results; buffer contents need not be cleared.
REQ-027 First accept possible at first rising edge with rst_n=1.

Verification
REQ-028 WIDTH=8: NOT a=8'h0F -> out_data=8'hF0; BUF a=8'hA5 -> 8'hA5.
REQ-029 WIDTH=8, a=8'hCC, b=8'hAA for all eight ops -> 33, 88, EE, 66, 77, 11, 99, CC in order.
REQ-030 DEPTH=4, out_ready=0, five requests -> in_ready=0 after fourth accept, count=4, fifth held; release out_ready -> five results in order.
REQ-031 count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, pointers wrap, order preserved.
REQ-032 rst_n low mid-stream with count=3 -> out_valid=0, count=0, in_ready=1 before next edge; prior results never emerge.
REQ-033 WIDTH=1, exhaustive a,b,op -> matches truth tables; out_data stable across 3 stalled cycles.
